// File: rtl/tblink_rpc_rvdemux_n.sv
// Ready/valid packet demultiplexer: routes each tblink RPC packet to one of N_TGT
// address-matched targets, the passthrough port, or a discard sink, with zero added latency.
module tblink_rpc_rvdemux_n #(
    parameter int unsigned ADDR_BASE      = 0,
    parameter int unsigned N_TGT          = 2,
    parameter int unsigned DAT_W          = 8,
    parameter int unsigned STRIP_HDR      = 1,
    parameter int unsigned DROP_UNMATCHED = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [DAT_W-1:0] i_dat,
    output logic [N_TGT-1:0] oa_valid,
    input  logic [N_TGT-1:0] oa_ready,
    output logic [DAT_W-1:0] oa_dat,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [DAT_W-1:0] op_dat,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned TGT_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA} state_t;
    typedef enum logic [1:0] {R_TGT, R_PASS, R_DROP} route_t;

    state_t             state, state_nxt;
    route_t             sel_kind, sel_kind_nxt;
    logic [TGT_W-1:0]   sel_tgt, sel_tgt_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [7:0]         drop_cnt_nxt;

    logic [6:0]         hdr_addr;
    logic [7:0]         hdr_off;
    logic               hdr_hit;
    route_t             hdr_kind;
    logic [TGT_W-1:0]   hdr_tgt;
    route_t             route_kind;
    logic [TGT_W-1:0]   route_tgt;
    logic               hs;

    assign oa_dat = i_dat;
    assign op_dat = i_dat;
    assign hs     = i_valid & i_ready;

    // Header decode; a stripped header on a hit is consumed like a dropped beat.
    always_comb begin : decode
        hdr_addr   = i_dat[6:0];
        hdr_off    = {1'b0, hdr_addr} - 8'(ADDR_BASE);
        hdr_hit    = ({1'b0, hdr_addr} >= 8'(ADDR_BASE)) && (hdr_off < 8'(N_TGT));
        hdr_tgt    = TGT_W'(hdr_off);
        hdr_kind   = hdr_hit ? R_TGT : ((DROP_UNMATCHED != 0) ? R_DROP : R_PASS);
        route_kind = sel_kind;
        route_tgt  = sel_tgt;
        if (state == S_IDLE) begin
            route_kind = (hdr_hit && (STRIP_HDR != 0)) ? R_DROP : hdr_kind;
            route_tgt  = hdr_tgt;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sel_kind <= R_PASS;
            sel_tgt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel_kind <= sel_kind_nxt;
            sel_tgt  <= sel_tgt_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_nxt    = state;
        cnt_nxt      = cnt;
        sel_kind_nxt = sel_kind;
        sel_tgt_nxt  = sel_tgt;
        drop_cnt_nxt = drop_cnt;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    state_nxt    = S_LEN;
                    sel_kind_nxt = hdr_kind;
                    sel_tgt_nxt  = hdr_tgt;
                    if ((hdr_kind == R_DROP) && (drop_cnt != 8'hFF)) begin
                        drop_cnt_nxt = drop_cnt + 8'd1;
                    end
                end
            end
            S_LEN: begin
                if (hs) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = i_dat[7:0];
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (cnt == 8'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output steering; everything is held inactive while reset is asserted.
    always_comb begin : outputs
        i_ready  = 1'b0;
        oa_valid = '0;
        op_valid = 1'b0;
        busy     = 1'b0;
        if (!reset) begin
            busy = (state != S_IDLE);
            case (route_kind)
                R_TGT: begin
                    for (int unsigned i = 0; i < N_TGT; i++) begin
                        if (route_tgt == TGT_W'(i)) begin
                            oa_valid[i] = i_valid;
                            i_ready     = oa_ready[i];
                        end
                    end
                end
                R_PASS: begin
                    op_valid = i_valid;
                    i_ready  = op_ready;
                end
                default: i_ready = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_tblink_rpc_rvdemux_n.sv
// Scoreboard bench for tblink_rpc_rvdemux_n: instance a strips headers and passes
// misses through, instance b keeps headers and drops misses.
module tb_tblink_rpc_rvdemux_n;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        drv_valid;
    logic [7:0]  drv_dat;
    int          cur;
    int          cyc = 0;

    logic        a_i_valid, a_i_ready, a_op_valid, a_op_ready, a_busy;
    logic [1:0]  a_oa_valid, a_oa_ready, a_rdy_set;
    logic [7:0]  a_oa_dat, a_op_dat, a_drop_cnt;
    logic        b_i_valid, b_i_ready, b_op_valid, b_op_ready, b_busy;
    logic [1:0]  b_oa_valid, b_oa_ready;
    logic [7:0]  b_oa_dat, b_op_dat, b_drop_cnt;
    logic        tog_en;
    logic [1:0]  tog_val;

    typedef struct {int dest; int dat;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    assign a_i_valid  = drv_valid && (cur == 0);
    assign b_i_valid  = drv_valid && (cur == 1);
    assign a_oa_ready = tog_en ? tog_val : a_rdy_set;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tblink_rpc_rvdemux_n #(.ADDR_BASE(4), .N_TGT(2), .DAT_W(8), .STRIP_HDR(1), .DROP_UNMATCHED(0)) dut_a (
        .clock(clock), .reset(reset),
        .i_valid(a_i_valid), .i_ready(a_i_ready), .i_dat(drv_dat),
        .oa_valid(a_oa_valid), .oa_ready(a_oa_ready), .oa_dat(a_oa_dat),
        .op_valid(a_op_valid), .op_ready(a_op_ready), .op_dat(a_op_dat),
        .busy(a_busy), .drop_cnt(a_drop_cnt)
    );

    tblink_rpc_rvdemux_n #(.ADDR_BASE(4), .N_TGT(2), .DAT_W(8), .STRIP_HDR(0), .DROP_UNMATCHED(1)) dut_b (
        .clock(clock), .reset(reset),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_dat(drv_dat),
        .oa_valid(b_oa_valid), .oa_ready(b_oa_ready), .oa_dat(b_oa_dat),
        .op_valid(b_op_valid), .op_ready(b_op_ready), .op_dat(b_op_dat),
        .busy(b_busy), .drop_cnt(b_drop_cnt)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Destination code: 0..1 target, 8 passthrough, 9 nothing, 15 several at once.
    function automatic int dest_of(logic [1:0] v, logic p);
        case ({p, v})
            3'b000:  return 9;
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 8;
            default: return 15;
        endcase
    endfunction

    always @(negedge clock) begin
        int d, x;
        exp_t e;
        if (!reset && a_i_valid && a_i_ready) begin
            d = dest_of(a_oa_valid, a_op_valid);
            x = (d == 8) ? int'(a_op_dat) : ((d == 9) ? -1 : int'(a_oa_dat));
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_beat: got dest %0d data %0d expected no beat", d, x);
            end else begin
                e = qa.pop_front();
                check("a_dest", d, e.dest);
                check("a_data", x, e.dat);
            end
        end
    end

    always @(negedge clock) begin
        int d, x;
        exp_t e;
        if (!reset && b_i_valid && b_i_ready) begin
            d = dest_of(b_oa_valid, b_op_valid);
            x = (d == 8) ? int'(b_op_dat) : ((d == 9) ? -1 : int'(b_oa_dat));
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_beat: got dest %0d data %0d expected no beat", d, x);
            end else begin
                e = qb.pop_front();
                check("b_dest", d, e.dest);
                check("b_data", x, e.dat);
            end
        end
    end

    always @(posedge clock) begin
        if (tog_en) begin
            #1 tog_val = 2'($urandom_range(0, 3));
        end
    end

    // Present one beat and wait (bounded) for its handshake.
    task automatic send(input int d, input int exp_dest, input int exp_dat);
        exp_t e;
        bit   hs;
        int   n;
        e.dest = exp_dest;
        e.dat  = exp_dat;
        if (cur == 0) qa.push_back(e); else qb.push_back(e);
        drv_valid = 1'b1;
        drv_dat   = 8'(d);
        n = 0;
        do begin
            @(negedge clock);
            hs = (cur == 0) ? a_i_ready : b_i_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!hs && n < 1000);
        if (!hs) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: got no i_ready for beat %0d expected a handshake", d);
        end
        drv_valid = 1'b0;
    endtask

    initial begin
        int c0;
        cur        = 0;
        drv_valid  = 1'b1;
        drv_dat    = 8'h05;
        a_rdy_set  = 2'b11;
        a_op_ready = 1'b1;
        b_oa_ready = 2'b11;
        b_op_ready = 1'b1;
        tog_en     = 1'b0;
        tog_val    = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_a_i_ready", a_i_ready, 0);
        check("rst_a_oa_valid", a_oa_valid, 0);
        check("rst_a_op_valid", a_op_valid, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_drop_cnt", a_drop_cnt, 0);
        cur = 1;
        #1;
        check("rst_b_i_ready", b_i_ready, 0);
        check("rst_b_drop_cnt", b_drop_cnt, 0);
        drv_valid = 1'b0;
        cur = 0;
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;

        // Stripped header to target 1
        send(8'h05, 9, -1);
        check("t1_busy_after_hdr", a_busy, 1);
        send(8'h02, 1, 8'h02);
        send(8'hA1, 1, 8'hA1);
        send(8'hB2, 1, 8'hB2);
        send(8'hC3, 1, 8'hC3);
        check("t1_busy_end", a_busy, 0);

        // Miss to passthrough, then hit with no bubble
        c0 = cyc;
        send(8'h10, 8, 8'h10);
        send(8'h00, 8, 8'h00);
        send(8'h58, 8, 8'h58);
        send(8'h04, 9, -1);
        send(8'h00, 0, 8'h00);
        send(8'h59, 0, 8'h59);
        check("t2_cycles_no_bubble", cyc - c0, 6);
        check("t2_a_drop_cnt", a_drop_cnt, 0);

        // Dropped miss on instance b
        cur = 1;
        check("t3_drop_cnt_before", b_drop_cnt, 0);
        c0 = cyc;
        send(8'h33, 9, -1);
        send(8'h01, 9, -1);
        send(8'h5A, 9, -1);
        send(8'h5B, 9, -1);
        check("t3_cycles", cyc - c0, 4);
        check("t3_drop_cnt_after", b_drop_cnt, 1);

        // Header kept on target 0; non-selected readies low
        b_oa_ready = 2'b01;
        b_op_ready = 1'b0;
        send(8'h04, 0, 8'h04);
        send(8'h01, 0, 8'h01);
        send(8'h77, 0, 8'h77);
        send(8'h78, 0, 8'h78);
        check("t4_busy_end", b_busy, 0);
        check("t4_drop_cnt", b_drop_cnt, 1);

        // Max-length packet under random backpressure
        cur    = 0;
        tog_en = 1'b1;
        send(8'h04, 9, -1);
        send(8'hFF, 0, 8'hFF);
        for (int i = 0; i < 255; i++) send(i, 0, i);
        check("t5_busy_before_last", a_busy, 1);
        send(8'hFF, 0, 8'hFF);
        check("t5_busy_end", a_busy, 0);
        tog_en = 1'b0;

        // Reset during DATA with cnt=5
        a_rdy_set = 2'b11;
        send(8'h05, 9, -1);
        send(8'h09, 1, 8'h09);
        for (int k = 0; k < 4; k++) send(8'h20 + k, 1, 8'h20 + k);
        drv_valid = 1'b1;
        drv_dat   = 8'h30;
        #1;
        check("t6_valid_before_rst", a_oa_valid, 2'b10);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_oa_valid", a_oa_valid, 0);
        check("t6_rst_op_valid", a_op_valid, 0);
        check("t6_rst_i_ready", a_i_ready, 0);
        check("t6_rst_busy", a_busy, 0);
        @(posedge clock);
        #3;
        reset     = 1'b0;
        drv_valid = 1'b0;
        @(posedge clock);
        #1;
        send(8'h05, 9, -1);
        send(8'h00, 1, 8'h00);
        send(8'h31, 1, 8'h31);
        check("t6_busy_end", a_busy, 0);

        repeat (3) @(posedge clock);
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
